// File: rtl/rgb_hue_scheduler.sv
// ---------------------------------------------------------------------------
// rgb_hue_scheduler
// Walks the board RGB LED around a six-segment hue wheel by generating one
// PWM duty per channel. A single requester can override the colour over a
// valid/ready handshake; the accepted colour is held for HOLD_CYCLES and the
// wheel then resumes from the position where it was frozen.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         1 = run; 0 = LED off, every counter and the state frozen
//   ovr_valid  override request valid (held by the requester until accepted)
//   ovr_rgb    override duties {r,g,b}, red in the MSBs
//   ovr_ready  override can be accepted this cycle
//   busy       1 while an override colour is being held
//   seg        current hue segment 0..5
//   RGB_R/G/B  active-low LED pads, registered
//
// Configuration
//   RGB_GAMMA_EN  when defined, every duty d is reshaped to (d*d)>>PWM_BITS
//                 before the PWM compare for a perceptually smoother fade.
// ---------------------------------------------------------------------------
module rgb_hue_scheduler #(
   parameter int STEP_CYCLES = 12000,
   parameter int PWM_BITS    = 8,
   parameter int HOLD_CYCLES = 12000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    ovr_valid,
   input  logic [3*PWM_BITS-1:0]   ovr_rgb,
   output logic                    ovr_ready,
   output logic                    busy,
   output logic [2:0]              seg,
   output logic                    RGB_R,
   output logic                    RGB_G,
   output logic                    RGB_B
);

   localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TW-1:0]       TICK_LAST = TW'(STEP_CYCLES - 1);
   localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] MAXV      = '1;

   typedef enum logic {CYCLE, HOLD} state_e;

   state_e                  state_q, state_d;
   logic [TW-1:0]           tick_q, tick_d;
   logic [PWM_BITS-1:0]     lvl_q, lvl_d;
   logic [2:0]              seg_q, seg_d;
   logic [PWM_BITS-1:0]     pwm_q, pwm_d;
   logic [HW-1:0]           hold_q, hold_d;
   logic [3*PWM_BITS-1:0]   held_q, held_d;
   logic [2:0]              rgb_q, rgb_d;

   logic [PWM_BITS-1:0]     wheelR, wheelG, wheelB;
   logic [PWM_BITS-1:0]     rawR, rawG, rawB;
   logic [PWM_BITS-1:0]     dutyR, dutyG, dutyB;
   logic [2:0]              chanOn;

   // Optional perceptual reshaping of a duty; linear pass-through otherwise.
   function automatic logic [PWM_BITS-1:0] shapeDuty(input logic [PWM_BITS-1:0] d);
`ifdef RGB_GAMMA_EN
      logic [2*PWM_BITS-1:0] sq;
      sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
      return PWM_BITS'(sq >> PWM_BITS);
`else
      return d;
`endif
   endfunction

   // Wheel colour for the current segment, override colour while holding,
   // then the per-channel PWM compare. Duty 0 never lights a channel.
   always_comb begin
      wheelR = '0;
      wheelG = '0;
      wheelB = '0;
      case (seg_q)
         3'd0: begin wheelR = MAXV;         wheelG = lvl_q;        end
         3'd1: begin wheelR = MAXV - lvl_q; wheelG = MAXV;         end
         3'd2: begin wheelG = MAXV;         wheelB = lvl_q;        end
         3'd3: begin wheelG = MAXV - lvl_q; wheelB = MAXV;         end
         3'd4: begin wheelR = lvl_q;        wheelB = MAXV;         end
         3'd5: begin wheelR = MAXV;         wheelB = MAXV - lvl_q; end
         default: ;
      endcase
      if (state_q == HOLD) begin
         rawR = held_q[3*PWM_BITS-1:2*PWM_BITS];
         rawG = held_q[2*PWM_BITS-1:PWM_BITS];
         rawB = held_q[PWM_BITS-1:0];
      end else begin
         rawR = wheelR;
         rawG = wheelG;
         rawB = wheelB;
      end
      dutyR  = shapeDuty(rawR);
      dutyG  = shapeDuty(rawG);
      dutyB  = shapeDuty(rawB);
      chanOn = {pwm_q < dutyR, pwm_q < dutyG, pwm_q < dutyB};
   end

   // Next-state logic. With en low nothing advances and the pads go dark.
   // In CYCLE the step timer runs even on the cycle an override is accepted,
   // so a coincident step completes and HOLD freezes the post-step position.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      lvl_d     = lvl_q;
      seg_d     = seg_q;
      pwm_d     = pwm_q;
      hold_d    = hold_q;
      held_d    = held_q;
      rgb_d     = 3'b111;
      ovr_ready = 1'b0;
      busy      = (state_q == HOLD);
      if (en && rst_n && state_q == CYCLE) begin
         ovr_ready = 1'b1;
      end
      if (en) begin
         pwm_d = pwm_q + PWM_BITS'(1);
         rgb_d = ~chanOn;
         case (state_q)
            CYCLE: begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (lvl_q == MAXV) begin
                     lvl_d = '0;
                     seg_d = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
                  end else begin
                     lvl_d = lvl_q + PWM_BITS'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
               if (ovr_valid) begin
                  held_d  = ovr_rgb;
                  hold_d  = '0;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  state_d = CYCLE;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
            default: state_d = CYCLE;
         endcase
      end
   end

   // State and counter registers; reset leaves the LED dark at wheel start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CYCLE;
         tick_q  <= '0;
         lvl_q   <= '0;
         seg_q   <= '0;
         pwm_q   <= '0;
         hold_q  <= '0;
         held_q  <= '0;
         rgb_q   <= 3'b111;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         lvl_q   <= lvl_d;
         seg_q   <= seg_d;
         pwm_q   <= pwm_d;
         hold_q  <= hold_d;
         held_q  <= held_d;
         rgb_q   <= rgb_d;
      end
   end

   assign seg   = seg_q;
   assign RGB_R = rgb_q[2];
   assign RGB_G = rgb_q[1];
   assign RGB_B = rgb_q[0];

endmodule

// File: tb/tb_rgb_hue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rgb_hue_scheduler
// Directed bench for rgb_hue_scheduler with PWM_BITS=2, STEP_CYCLES=2,
// HOLD_CYCLES=8. A behavioural model tracks the wheel as a single position
// 0..23 (segment*4 + level); every clock the expected post-edge outputs are
// pushed to a scoreboard and popped/compared after the edge.
// ---------------------------------------------------------------------------
module tb_rgb_hue_scheduler;

   localparam int PB = 2;
   localparam int SC = 2;
   localparam int HC = 8;
   localparam int MX = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en = 1'b0;
   logic          ovr_valid = 1'b0;
   logic [3*PB-1:0] ovr_rgb = '0;
   logic          ovr_ready;
   logic          busy;
   logic [2:0]    seg;
   logic          RGB_R, RGB_G, RGB_B;
   logic [2:0]    pads;

   assign pads = {RGB_R, RGB_G, RGB_B};

   rgb_hue_scheduler #(
      .STEP_CYCLES(SC),
      .PWM_BITS(PB),
      .HOLD_CYCLES(HC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .ovr_valid(ovr_valid),
      .ovr_rgb(ovr_rgb),
      .ovr_ready(ovr_ready),
      .busy(busy),
      .seg(seg),
      .RGB_R(RGB_R),
      .RGB_G(RGB_G),
      .RGB_B(RGB_B)
   );

   // Free-running 10-unit clock.
   initial begin
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [2:0] pads;
      logic [2:0] seg;
      logic       busy;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   int mPwm, mTick, mPos, mHoldCnt;
   bit mHold;
   int mHeld[3];
   int lowR, lowG, lowB;

   function automatic int shapeD(input int d);
`ifdef RGB_GAMMA_EN
      return (d * d) >> PB;
`else
      return d;
`endif
   endfunction

   // Wheel duty of channel ch (0=r,1=g,2=b) at wheel position pos.
   function automatic int wheelDuty(input int ch, input int pos);
      int s, l, r, g, b;
      s = pos / 4;
      l = pos % 4;
      r = 0; g = 0; b = 0;
      case (s)
         0: begin r = MX;     g = l;      end
         1: begin r = MX - l; g = MX;     end
         2: begin g = MX;     b = l;      end
         3: begin g = MX - l; b = MX;     end
         4: begin r = l;      b = MX;     end
         default: begin r = MX; b = MX - l; end
      endcase
      return (ch == 0) ? r : (ch == 1) ? g : b;
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mPwm = 0; mTick = 0; mPos = 0; mHoldCnt = 0; mHold = 1'b0;
      for (int i = 0; i < 3; i++) mHeld[i] = 0;
      sb.delete();
   endtask

   // One clock with the currently driven inputs: check ready, predict the
   // edge, push the prediction, take the edge, pop and compare.
   task automatic applyStimulus();
      exp_t e, got;
      int d[3];
      logic [2:0] nextPads;
      #1;
      checkOutput("ovr_ready", 8'(ovr_ready), 8'(en && !mHold));
      for (int c = 0; c < 3; c++) begin
         d[c] = shapeD(mHold ? mHeld[c] : wheelDuty(c, mPos));
      end
      nextPads = 3'b111;
      if (en) begin
         nextPads = ~{mPwm < d[0], mPwm < d[1], mPwm < d[2]};
         mPwm = (mPwm + 1) % 4;
         if (!mHold) begin
            mTick++;
            if (mTick == SC) begin
               mTick = 0;
               mPos  = (mPos + 1) % 24;
            end
            if (ovr_valid) begin
               mHeld[0] = int'(ovr_rgb[5:4]);
               mHeld[1] = int'(ovr_rgb[3:2]);
               mHeld[2] = int'(ovr_rgb[1:0]);
               mHoldCnt = 0;
               mHold    = 1'b1;
            end
         end else begin
            mHoldCnt++;
            if (mHoldCnt == HC) mHold = 1'b0;
         end
      end
      e.pads = nextPads;
      e.seg  = 3'(mPos / 4);
      e.busy = mHold;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      checkOutput("pads", 8'(pads), 8'(got.pads));
      checkOutput("seg", 8'(seg), 8'(got.seg));
      checkOutput("busy", 8'(busy), 8'(got.busy));
      if (!RGB_R) lowR++;
      if (!RGB_G) lowG++;
      if (!RGB_B) lowB++;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_pads"}, 8'(pads), 8'd7);
      checkOutput({tag, "_seg"}, 8'(seg), 8'd0);
      checkOutput({tag, "_busy"}, 8'(busy), 8'd0);
      checkOutput({tag, "_ready"}, 8'(ovr_ready), 8'd0);
   endtask

   initial begin
      // Reset with en already high: outputs must sit at reset values.
      en = 1'b1;
      #2 rst_n = 1'b0;
      #20;
      checkResetState("rst");
      resetModel();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Free-running wheel: first segment change after 4 steps of 2 clocks.
      repeat (7) applyStimulus();
      checkOutput("seg_after7", 8'(seg), 8'd0);
      applyStimulus();
      checkOutput("seg_after8", 8'(seg), 8'd1);
      repeat (40) applyStimulus();
      checkOutput("seg_after48", 8'(seg), 8'd0);

      // Segment 0: red at full duty, blue off.
      lowR = 0; lowG = 0; lowB = 0;
      repeat (8) applyStimulus();
`ifdef RGB_GAMMA_EN
      checkOutput("seg0_red_lows", 8'(lowR), 8'd4);
`else
      checkOutput("seg0_red_lows", 8'(lowR), 8'd6);
`endif
      checkOutput("seg0_blue_lows", 8'(lowB), 8'd0);

      // Override with full red; hold lasts 8 clocks.
      ovr_rgb = 6'b11_00_00;
      ovr_valid = 1'b1;
      applyStimulus();
      ovr_valid = 1'b0;
      checkOutput("ovr_busy", 8'(busy), 8'd1);
      lowR = 0; lowG = 0; lowB = 0;
      repeat (8) applyStimulus();
`ifdef RGB_GAMMA_EN
      checkOutput("hold_red_lows", 8'(lowR), 8'd4);
`else
      checkOutput("hold_red_lows", 8'(lowR), 8'd6);
`endif
      checkOutput("hold_gb_lows", 8'(lowG + lowB), 8'd0);
      repeat (5) applyStimulus();

      // Request kept asserted through a HOLD with a new colour.
      ovr_rgb = 6'b00_11_00;
      ovr_valid = 1'b1;
      applyStimulus();
      ovr_rgb = 6'b00_00_11;
      repeat (12) applyStimulus();
      ovr_valid = 1'b0;
      repeat (10) applyStimulus();

      // en low for 20 clocks mid-segment, then resume.
      en = 1'b0;
      lowR = 0; lowG = 0; lowB = 0;
      repeat (20) applyStimulus();
      checkOutput("en_off_lows", 8'(lowR + lowG + lowB), 8'd0);
      en = 1'b1;
      repeat (10) applyStimulus();

      // Reset pulse in the middle of a HOLD.
      ovr_rgb = 6'b00_00_10;
      ovr_valid = 1'b1;
      applyStimulus();
      ovr_valid = 1'b0;
      repeat (3) applyStimulus();
      rst_n = 1'b0;
      #1;
      checkResetState("midhold_rst");
      resetModel();
      #1 rst_n = 1'b1;
      repeat (5) applyStimulus();

      // Half-duty red override; gamma maps duty 2 down to 1.
      ovr_rgb = 6'b10_00_00;
      ovr_valid = 1'b1;
      applyStimulus();
      ovr_valid = 1'b0;
      lowR = 0; lowG = 0; lowB = 0;
      repeat (8) applyStimulus();
`ifdef RGB_GAMMA_EN
      checkOutput("half_red_lows", 8'(lowR), 8'd2);
`else
      checkOutput("half_red_lows", 8'(lowR), 8'd4);
`endif
      repeat (4) applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
